// File: rtl/cic_pkg.sv
// Shared definitions for the CIC filter control path: sequencer states and
// default filter geometry, including the decimation-ratio width used by the decimator.
package cic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RELEASE = 2'b01,
        ST_SETTLE  = 2'b10,
        ST_RUN     = 2'b11
    } seq_state_t;

    localparam int CIC_N_STAGES = 3;
    localparam int CIC_SETTLE   = 3;
    localparam int CIC_DECIM_W  = 8;

endpackage

// File: rtl/cic_sequencer_if.sv
// Control/status bundle between the CIC sequencer (slave) and the filter top (master).
interface cic_sequencer_if
    import cic_pkg::*;
#(
    parameter int N_STAGES = CIC_N_STAGES,
    parameter int DECIM_W  = CIC_DECIM_W
) ();

    logic                enable;
    logic [DECIM_W-1:0]  ratio_m1;
    logic                tx_busy;
    logic                clr_ovr;
    logic [N_STAGES-1:0] stage_rst_n;
    logic                comb_rst_n;
    logic                decim_stb;
    logic                out_valid;
    logic                overrun;
    logic [1:0]          state;

    modport master (
        output enable, ratio_m1, tx_busy, clr_ovr,
        input  stage_rst_n, comb_rst_n, decim_stb, out_valid, overrun, state
    );

    modport slave (
        input  enable, ratio_m1, tx_busy, clr_ovr,
        output stage_rst_n, comb_rst_n, decim_stb, out_valid, overrun, state
    );

endinterface

// File: rtl/cic_sequencer_phase_counter.sv
// Loadable modulo-(i_last+1) counter; o_wrap is high in the cycle the count sits at i_last.
module decim_phase_counter
    import cic_pkg::*;
#(
    parameter int W = CIC_DECIM_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clear,
    input  logic         i_en,
    input  logic [W-1:0] i_last,
    output logic         o_wrap
);

    logic [W-1:0] r_count;

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == i_last) ? '0 : r_count + W'(1);
        end
    end

    assign o_wrap = i_en && !i_clear && (r_count == i_last);

endmodule

// File: rtl/cic_sequencer.sv
// CIC control sequencer: staggered stage-reset release, decimation strobe,
// settling-sample discard and serializer hand-off with sticky overrun.
module cic_sequencer
    import cic_pkg::*;
#(
    parameter int N_STAGES = CIC_N_STAGES,
    parameter int DECIM_W  = CIC_DECIM_W,
    parameter int SETTLE   = CIC_SETTLE
) (
    input  logic           clk,
    input  logic           rst_n,
    cic_sequencer_if.slave bus
);

    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    seq_state_t          r_state, w_state_nxt;
    logic [N_STAGES-1:0] r_stage_rst_n, w_stage_nxt;
    logic                r_comb_rst_n, w_comb_nxt;
    logic                r_decim_stb, w_stb_nxt;
    logic                r_out_valid, w_ov_nxt;
    logic                r_overrun, w_ovr_nxt;
    logic [DECIM_W-1:0]  r_last, w_last_nxt;
    logic [SCW-1:0]      r_settle_cnt, w_settle_nxt;
    logic                w_cnt_en;
    logic                w_cnt_wrap;

    assign w_cnt_en = ((r_state == ST_SETTLE) || (r_state == ST_RUN)) && bus.enable;

    decim_phase_counter #(.W(DECIM_W)) u_phase (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (!w_cnt_en),
        .i_en    (w_cnt_en),
        .i_last  (r_last),
        .o_wrap  (w_cnt_wrap)
    );

    // NOTE: every signal gets its default first, so no path through the case infers a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_stage_nxt  = r_stage_rst_n;
        w_comb_nxt   = r_comb_rst_n;
        w_stb_nxt    = 1'b0;
        w_ov_nxt     = 1'b0;
        w_last_nxt   = r_last;
        w_settle_nxt = r_settle_cnt;

        case (r_state)
            ST_IDLE: begin
                w_stage_nxt  = '0;
                w_comb_nxt   = 1'b0;
                w_settle_nxt = '0;
                if (bus.enable) begin
                    // R = 1 cannot produce a separate strobe/load cycle, so clamp to R = 2.
                    w_last_nxt  = (bus.ratio_m1 == '0) ? DECIM_W'(1) : bus.ratio_m1;
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (&r_stage_rst_n) begin
                    w_comb_nxt  = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_stage_nxt = (r_stage_rst_n << 1) | N_STAGES'(1);
                end
            end
            ST_SETTLE: begin
                w_stb_nxt = w_cnt_wrap;
                if (r_decim_stb) begin
                    if (r_settle_cnt == SCW'(SETTLE - 1)) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_settle_nxt = r_settle_cnt + SCW'(1);
                    end
                end
            end
            ST_RUN: begin
                w_stb_nxt = w_cnt_wrap;
                w_ov_nxt  = r_decim_stb;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if ((r_state != ST_IDLE) && !bus.enable) begin
            w_state_nxt = ST_IDLE;
            w_stage_nxt = '0;
            w_comb_nxt  = 1'b0;
            w_stb_nxt   = 1'b0;
            w_ov_nxt    = 1'b0;
        end

        // A new overrun outranks a simultaneous clear.
        if (w_ov_nxt && bus.tx_busy) begin
            w_ovr_nxt = 1'b1;
        end else if (bus.clr_ovr) begin
            w_ovr_nxt = 1'b0;
        end else begin
            w_ovr_nxt = r_overrun;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage_rst_n <= '0;
            r_comb_rst_n  <= 1'b0;
            r_decim_stb   <= 1'b0;
            r_out_valid   <= 1'b0;
            r_overrun     <= 1'b0;
            r_last        <= DECIM_W'(1);
            r_settle_cnt  <= '0;
        end else begin
            r_stage_rst_n <= w_stage_nxt;
            r_comb_rst_n  <= w_comb_nxt;
            r_decim_stb   <= w_stb_nxt;
            r_out_valid   <= w_ov_nxt;
            r_overrun     <= w_ovr_nxt;
            r_last        <= w_last_nxt;
            r_settle_cnt  <= w_settle_nxt;
        end
    end

    assign bus.stage_rst_n = r_stage_rst_n;
    assign bus.comb_rst_n  = r_comb_rst_n;
    assign bus.decim_stb   = r_decim_stb;
    assign bus.out_valid   = r_out_valid;
    assign bus.overrun     = r_overrun;
    assign bus.state       = r_state;

endmodule

// File: tb/tb_cic_sequencer.sv
// Bench for cic_sequencer: closed-form timing model checked every cycle,
// plus literal checkpoints for release, settle, overrun, abort, clamp and period.
module tb_cic_sequencer;
    import cic_pkg::*;

    localparam int N   = 3;
    localparam int SET = 3;
    localparam int DW  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cic_sequencer_if #(.N_STAGES(N), .DECIM_W(DW)) bus ();

    cic_sequencer #(.N_STAGES(N), .DECIM_W(DW), .SETTLE(SET)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: a run is described only by its start edge and R; outputs follow from the offset.
    bit         m_run   = 1'b0;
    int         m_start = 0;
    int         m_r     = 2;
    bit         m_ovr   = 1'b0;
    int         m_t, m_u, m_v;
    logic [N-1:0] e_stage = '0;
    logic       e_comb  = 1'b0;
    logic       e_stb   = 1'b0;
    logic       e_ov    = 1'b0;
    logic [1:0] e_state = 2'd0;

    int stb_cnt   = 0;
    int ov_cnt    = 0;
    int last_stb  = -1;
    int gap_stbs  = 0;
    bit chk_gap   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run   = 1'b0;
            m_ovr   = 1'b0;
            e_stage = '0;
            e_comb  = 1'b0;
            e_stb   = 1'b0;
            e_ov    = 1'b0;
            e_state = 2'd0;
        end else begin
            cyc = cyc + 1;
            if (!m_run) begin
                if (bus.enable) begin
                    m_run   = 1'b1;
                    m_start = cyc;
                    m_r     = (bus.ratio_m1 == 0) ? 2 : int'(bus.ratio_m1) + 1;
                end
            end else if (!bus.enable) begin
                m_run = 1'b0;
            end
            if (m_run) begin
                m_t = cyc - m_start;
                for (int k = 0; k < N; k++) e_stage[k] = (m_t >= k + 1);
                e_comb  = (m_t >= N + 1);
                m_u     = m_t - (N + 1);
                e_stb   = (m_u > 0) && (m_u % m_r == 0);
                m_v     = m_t - (N + 2);
                e_ov    = (m_v >= 0) && (m_v % m_r == 0) && (m_v / m_r >= SET + 1);
                e_state = (m_t <= N) ? 2'd1 : (m_t <= N + 1 + SET * m_r) ? 2'd2 : 2'd3;
            end else begin
                e_stage = '0;
                e_comb  = 1'b0;
                e_stb   = 1'b0;
                e_ov    = 1'b0;
                e_state = 2'd0;
            end
            if (e_ov && bus.tx_busy) m_ovr = 1'b1;
            else if (bus.clr_ovr)    m_ovr = 1'b0;
        end
    end

    always @(negedge clk) begin
        check("stage_rst_n", 32'(bus.stage_rst_n), 32'(e_stage));
        check("comb_rst_n",  32'(bus.comb_rst_n),  32'(e_comb));
        check("decim_stb",   32'(bus.decim_stb),   32'(e_stb));
        check("out_valid",   32'(bus.out_valid),   32'(e_ov));
        check("overrun",     32'(bus.overrun),     32'(m_ovr));
        check("state",       32'(bus.state),       32'(e_state));
        if (bus.decim_stb === 1'b1) begin
            stb_cnt++;
            if (chk_gap) begin
                if (last_stb >= 0) check("stb_gap", 32'(cyc - last_stb), 32'd256);
                last_stb = cyc;
                gap_stbs++;
            end
        end
        if (bus.out_valid === 1'b1) ov_cnt++;
    end

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Literal release/settle/run timeline for R = 4 and a start edge at cycle s.
    task automatic check_seq(input int s);
        wait_to(s + 1);  check("rel_k0", 32'(bus.stage_rst_n), 32'b001);
                         check("rel_state", 32'(bus.state), 32'd1);
        wait_to(s + 2);  check("rel_k1", 32'(bus.stage_rst_n), 32'b011);
        wait_to(s + 3);  check("rel_k2", 32'(bus.stage_rst_n), 32'b111);
                         check("comb_low", 32'(bus.comb_rst_n), 32'd0);
        wait_to(s + 4);  check("comb_high", 32'(bus.comb_rst_n), 32'd1);
                         check("settle_state", 32'(bus.state), 32'd2);
        wait_to(s + 7);  check("stb_early", 32'(bus.decim_stb), 32'd0);
        wait_to(s + 8);  check("stb_first", 32'(bus.decim_stb), 32'd1);
        wait_to(s + 9);  check("ov_settle", 32'(bus.out_valid), 32'd0);
        wait_to(s + 16); check("stb_third", 32'(bus.decim_stb), 32'd1);
        wait_to(s + 17); check("ov_none", 32'(bus.out_valid), 32'd0);
                         check("run_state", 32'(bus.state), 32'd3);
        wait_to(s + 20); check("stb_fourth", 32'(bus.decim_stb), 32'd1);
        wait_to(s + 21); check("ov_first", 32'(bus.out_valid), 32'd1);
        wait_to(s + 25); check("ov_second", 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int s, s2, s3, s4;
        bus.enable   = 1'b0;
        bus.ratio_m1 = '0;
        bus.tx_busy  = 1'b0;
        bus.clr_ovr  = 1'b0;
        #2;
        check("rst_stage", 32'(bus.stage_rst_n), 32'd0);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_stb",   32'(bus.decim_stb), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        wait_to(cyc + 100);
        check("idle_quiet", 32'(stb_cnt + ov_cnt), 32'd0);
        check("idle_state", 32'(bus.state), 32'd0);

        // Nominal run, R = 4; the later ratio change must be ignored.
        bus.ratio_m1 = 8'd3;
        bus.enable   = 1'b1;
        s = cyc + 1;
        wait_to(s);
        bus.ratio_m1 = 8'd7;
        check_seq(s);

        wait_to(s + 28); bus.tx_busy = 1'b1;
        wait_to(s + 29); check("ovr_pulse", 32'(bus.out_valid), 32'd1);
                         check("ovr_set", 32'(bus.overrun), 32'd1);
        wait_to(s + 30); bus.tx_busy = 1'b0;
        wait_to(s + 32); bus.tx_busy = 1'b1; bus.clr_ovr = 1'b1;
        wait_to(s + 33); check("ovr_pulse2", 32'(bus.out_valid), 32'd1);
                         check("ovr_set_wins", 32'(bus.overrun), 32'd1);
                         bus.tx_busy = 1'b0; bus.clr_ovr = 1'b0;

        // Abort one cycle before the strobe expected at s+36.
        wait_to(s + 35); bus.enable = 1'b0;
        wait_to(s + 36); check("abort_state", 32'(bus.state), 32'd0);
                         check("abort_stage", 32'(bus.stage_rst_n), 32'd0);
                         check("abort_comb", 32'(bus.comb_rst_n), 32'd0);
                         check("abort_stb", 32'(bus.decim_stb), 32'd0);
                         check("abort_ovr_kept", 32'(bus.overrun), 32'd1);
        wait_to(s + 37); bus.clr_ovr = 1'b1;
        wait_to(s + 38); check("ovr_clear", 32'(bus.overrun), 32'd0);
                         bus.clr_ovr  = 1'b0;
                         bus.ratio_m1 = 8'd3;
                         bus.enable   = 1'b1;
        s2 = s + 39;
        check_seq(s2);
        wait_to(s2 + 26); bus.enable = 1'b0;
        wait_to(s2 + 27); check("stop_state", 32'(bus.state), 32'd0);

        // Ratio clamp: ratio_m1 = 0 runs at R = 2, mid-run change ignored.
        wait_to(cyc + 2);
        bus.ratio_m1 = 8'd0;
        bus.enable   = 1'b1;
        s3 = cyc + 1;
        wait_to(s3 + 6);  check("clamp_stb1", 32'(bus.decim_stb), 32'd1);
        wait_to(s3 + 7);  check("clamp_gap", 32'(bus.decim_stb), 32'd0);
        wait_to(s3 + 8);  check("clamp_stb2", 32'(bus.decim_stb), 32'd1);
        wait_to(s3 + 13); check("clamp_ov1", 32'(bus.out_valid), 32'd1);
        wait_to(s3 + 14); bus.ratio_m1 = 8'd9;
        wait_to(s3 + 20); check("clamp_keep1", 32'(bus.decim_stb), 32'd1);
        wait_to(s3 + 21); check("clamp_keep_gap", 32'(bus.decim_stb), 32'd0);
        wait_to(s3 + 22); check("clamp_keep2", 32'(bus.decim_stb), 32'd1);
                          bus.enable = 1'b0;
        wait_to(s3 + 23); check("pending_ov_dropped", 32'(bus.out_valid), 32'd0);
                          check("pending_state", 32'(bus.state), 32'd0);

        // Long-period run, R = 256, across the settle-to-run boundary.
        wait_to(cyc + 2);
        bus.ratio_m1 = 8'd255;
        bus.enable   = 1'b1;
        s4 = cyc + 1;
        last_stb = -1;
        gap_stbs = 0;
        chk_gap  = 1'b1;
        wait_to(s4 + N + 1 + 130 * 256 + 2);
        chk_gap = 1'b0;
        check("gap_count", 32'(gap_stbs), 32'd130);
        bus.enable = 1'b0;

        // Asynchronous reset in the middle of RUN, while out_valid is high.
        wait_to(cyc + 2);
        bus.ratio_m1 = 8'd3;
        bus.enable   = 1'b1;
        s = cyc + 1;
        wait_to(s + 29);
        check("pre_rst_state", 32'(bus.state), 32'd3);
        check("pre_rst_ov", 32'(bus.out_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_stage", 32'(bus.stage_rst_n), 32'd0);
        check("arst_comb", 32'(bus.comb_rst_n), 32'd0);
        check("arst_ov", 32'(bus.out_valid), 32'd0);
        check("arst_state", 32'(bus.state), 32'd0);
        @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_to(cyc + 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
